vga_image_ctrl: RTL



---
 rtl/vga_image_ctrl_if.sv | 43 ++++
 rtl/vga_image_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/vga_image_ctrl_if.sv
// Bundle of the image-ROM row port and the VGA pin group.
// Latency: none, wires only.
// Backpressure: none; the controller free-runs at the pixel clock.
interface vga_image_ctrl_if;
   logic [5:0]  rom_addr;
   logic [63:0] red_rom_data;
   logic [63:0] green_rom_data;
   logic [63:0] blue_rom_data;
   logic        vga_hsync;
   logic        vga_vsync;
   logic        vga_de;
   logic [4:0]  vga_red;
   logic [5:0]  vga_green;
   logic [4:0]  vga_blue;

   // Controller side: drives the ROM address and the VGA pins
   modport master (
      output rom_addr,
      input  red_rom_data,
      input  green_rom_data,
      input  blue_rom_data,
      output vga_hsync,
      output vga_vsync,
      output vga_de,
      output vga_red,
      output vga_green,
      output vga_blue
   );

   // ROM / display side
   modport slave (
      input  rom_addr,
      output red_rom_data,
      output green_rom_data,
      output blue_rom_data,
      input  vga_hsync,
      input  vga_vsync,
      input  vga_de,
      input  vga_red,
      input  vga_green,
      input  vga_blue
   );
endinterface

// File: rtl/vga_image_ctrl.sv
// 640x480@60 VGA timing generator painting a 64x64 1bpp RGB image from row ROMs.
// Latency: counter state to pins is 3 cycles; syncs and de share that delay.
// Backpressure: none; free-running, ROMs must answer one cycle after rom_addr.
module vga_image_ctrl #(
   parameter int IMG_X0 = 288,
   parameter int IMG_Y0 = 208
) (
   input logic             clk,
   input logic             rst_n,
   vga_image_ctrl_if.master bus
);

   localparam logic [9:0] H_LAST    = 10'd799;
   localparam logic [9:0] V_LAST    = 10'd524;
   localparam logic [9:0] H_VIS     = 10'd640;
   localparam logic [9:0] V_VIS     = 10'd480;
   localparam logic [9:0] HS_START  = 10'd656;
   localparam logic [9:0] HS_END    = 10'd752;
   localparam logic [9:0] VS_START  = 10'd490;
   localparam logic [9:0] VS_END    = 10'd492;
   localparam logic [9:0] X_START   = 10'(IMG_X0);
   localparam logic [9:0] X_END     = 10'(IMG_X0 + 64);
   localparam logic [9:0] Y_START   = 10'(IMG_Y0);
   localparam logic [9:0] Y_END     = 10'(IMG_Y0 + 64);
   // Only the low 6 bits of the 10-bit differences are ever used, and those
   // depend only on the low 6 bits of the operands.
   localparam logic [5:0] X_OFF     = X_START[5:0];
   localparam logic [5:0] Y_OFF     = Y_START[5:0];

   // Stage 0: counters
   logic [9:0] h_cnt_q, h_cnt_d;
   logic [9:0] v_cnt_q, v_cnt_d;

   // Stage 0 decode
   logic       de0, hs0, vs0, in_rows0, in_img0;
   logic [5:0] row0, col0;

   // Stage 1
   logic [5:0] rom_addr_q, rom_addr_d;
   logic [5:0] col1_q;
   logic       in_img1_q, de1_q, hs1_q, vs1_q;

   // Stage 2
   logic [5:0] col2_q;
   logic       in_img2_q, de2_q, hs2_q, vs2_q;

   // Stage 3: pin registers
   logic [4:0] red_q, red_d;
   logic [5:0] green_q, green_d;
   logic [4:0] blue_q, blue_d;
   logic       hsync_q, vsync_q, de_q;

   logic [5:0] bit_idx;
   logic       red_bit, green_bit, blue_bit, paint;

   // Raster counters: h wraps at 799, v advances on h wrap and wraps at 524
   always_comb begin
      h_cnt_d = h_cnt_q + 10'd1;
      v_cnt_d = v_cnt_q;
      if (h_cnt_q == H_LAST) begin
         h_cnt_d = '0;
         v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
      end
   end

   // Counter state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   // Timing regions and image window for the current counter position
   always_comb begin
      de0      = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
      hs0      = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
      vs0      = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
      in_rows0 = (v_cnt_q >= Y_START) && (v_cnt_q < Y_END);
      in_img0  = in_rows0 && (h_cnt_q >= X_START) && (h_cnt_q < X_END);
      row0     = v_cnt_q[5:0] - Y_OFF;
      col0     = h_cnt_q[5:0] - X_OFF;
   end

   // ROM row address only moves on image lines so the ROMs stay idle elsewhere
   always_comb begin
      rom_addr_d = in_rows0 ? row0 : rom_addr_q;
   end

   // Stage 1: issue ROM address, carry column and timing flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rom_addr_q <= '0;
         col1_q     <= '0;
         in_img1_q  <= 1'b0;
         de1_q      <= 1'b0;
         hs1_q      <= 1'b1;
         vs1_q      <= 1'b1;
      end else begin
         rom_addr_q <= rom_addr_d;
         col1_q     <= col0;
         in_img1_q  <= in_img0;
         de1_q      <= de0;
         hs1_q      <= hs0;
         vs1_q      <= vs0;
      end
   end

   // Stage 2: wait out the ROM read latency so flags line up with row data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col2_q    <= '0;
         in_img2_q <= 1'b0;
         de2_q     <= 1'b0;
         hs2_q     <= 1'b1;
         vs2_q     <= 1'b1;
      end else begin
         col2_q    <= col1_q;
         in_img2_q <= in_img1_q;
         de2_q     <= de1_q;
         hs2_q     <= hs1_q;
         vs2_q     <= vs1_q;
      end
   end

   // Pixel select: bit 63 is the leftmost pixel, so index is 63 - col
   always_comb begin
      bit_idx   = ~col2_q;
      red_bit   = bus.red_rom_data[bit_idx];
      green_bit = bus.green_rom_data[bit_idx];
      blue_bit  = bus.blue_rom_data[bit_idx];
      paint     = in_img2_q && de2_q;
      red_d     = (paint && red_bit)   ? 5'h1F : 5'h00;
      green_d   = (paint && green_bit) ? 6'h3F : 6'h00;
      blue_d    = (paint && blue_bit)  ? 5'h1F : 5'h00;
   end

   // Stage 3: output registers, reset drives idle pin levels immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         red_q   <= '0;
         green_q <= '0;
         blue_q  <= '0;
         hsync_q <= 1'b1;
         vsync_q <= 1'b1;
         de_q    <= 1'b0;
      end else begin
         red_q   <= red_d;
         green_q <= green_d;
         blue_q  <= blue_d;
         hsync_q <= hs2_q;
         vsync_q <= vs2_q;
         de_q    <= de2_q;
      end
   end

   assign bus.rom_addr  = rom_addr_q;
   assign bus.vga_red   = red_q;
   assign bus.vga_green = green_q;
   assign bus.vga_blue  = blue_q;
   assign bus.vga_hsync = hsync_q;
   assign bus.vga_vsync = vsync_q;
   assign bus.vga_de    = de_q;

endmodule
